// File: rtl/ram_bank_pkg.sv
// Shared constants for ram_bank: control levels, FSM encodings, byte-lane width
// and the per-lane parity helper.
package ram_bank_pkg;

  localparam logic RST_ACTIVE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam int   LANE_W       = 8;
  localparam logic [LANE_W-1:0] ZERO_LANE = '0;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_RUN   = 1'b1
  } ram_state_e;

  function automatic logic lane_parity(input logic [LANE_W-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/ram_bank_rdpipe.sv
// Output side of the ram_bank read path. The first latency stage is the memory
// read register in the top; READ_LATENCY=2 adds one more valid/data/perr stage here.
module ram_bank_rdpipe
  import ram_bank_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_perr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_perr
);

  generate
    if (READ_LATENCY >= 2) begin : g_extra
      logic              r_valid;
      logic              r_perr;
      logic [DATA_W-1:0] r_data;

      // Data only advances with a valid beat so the output holds between reads.
      always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
          r_valid <= 1'b0;
          r_perr  <= 1'b0;
          r_data  <= '0;
        end else begin
          r_valid <= i_valid;
          r_perr  <= i_valid && i_perr;
          if (i_valid) r_data <= i_data;
        end
      end

      assign o_valid = r_valid;
      assign o_data  = r_data;
      assign o_perr  = r_perr;
    end else begin : g_direct
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_valid  = i_valid;
      assign o_data   = i_data;
      assign o_perr   = i_valid && i_perr;
    end
  endgenerate

endmodule

// File: rtl/ram_bank.sv
// ram_bank: separate write/read port word RAM with byte strobes and a post-reset
// clear sweep. Define RAM_BANK_PARITY_EN to store and check one even-parity bit per lane.
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4096,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int RDW_NEW      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready_o,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  rvalid_o,
  output logic                  perr_o,
  input  logic                  perr_inject_i
);

  localparam int NB    = DATA_W / LANE_W;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  ram_state_e        r_state;
  logic [IDX_W-1:0]  r_clr_idx;
  logic              r_ready;

  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_ridx;
  logic              w_user_wr;
  logic              w_rd_go;

  assign w_widx    = waddr_i[OFF_W +: IDX_W];
  assign w_ridx    = raddr_i[OFF_W +: IDX_W];
  assign w_user_wr = (r_state == RAM_RUN) && (we_i == WRITE_ENABLE) && (|wstrb_i);
  assign w_rd_go   = (r_state == RAM_RUN) && re_i;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      r_state   <= RAM_CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else if (r_state == RAM_CLEAR) begin
      r_clr_idx <= r_clr_idx + 1'b1;
      if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
        r_state <= RAM_RUN;
        r_ready <= 1'b1;
      end
    end
  end

  assign ready_o = r_ready;

  // Single physical write port shared by the clear sweep and user writes.
  logic [IDX_W-1:0]  w_wr_idx;
  logic [NB-1:0]     w_wr_strb;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_wr_inj;

  always_comb begin
    w_wr_idx  = r_clr_idx;
    w_wr_strb = '0;
    w_wr_data = {NB{ZERO_LANE}};
    w_wr_inj  = 1'b0;
    if (rst != RST_ACTIVE) begin
      if (r_state == RAM_CLEAR) begin
        w_wr_strb = '1;
      end else if (w_user_wr) begin
        w_wr_idx  = w_widx;
        w_wr_strb = wstrb_i;
        w_wr_data = wdata_i;
        w_wr_inj  = perr_inject_i;
      end
    end
  end

  logic              r_rd_valid;
  logic              r_byp_hit;
  logic [NB-1:0]     r_byp_strb;
  logic [DATA_W-1:0] r_byp_data;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      r_rd_valid <= 1'b0;
      r_byp_hit  <= 1'b0;
      r_byp_strb <= '0;
      r_byp_data <= '0;
    end else begin
      r_rd_valid <= w_rd_go;
      if (w_rd_go) begin
        r_byp_hit  <= (RDW_NEW != 0) && w_user_wr && (w_widx == w_ridx);
        r_byp_strb <= wstrb_i;
        r_byp_data <= wdata_i;
      end
    end
  end

  logic [DATA_W-1:0] w_rd_data;
  logic [NB-1:0]     w_lane_perr;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [LANE_W-1:0] r_mem [DEPTH];
      logic [LANE_W-1:0] r_rd;
      logic              w_byp;

      always_ff @(posedge clk) begin
        if (w_wr_strb[gi]) r_mem[w_wr_idx] <= w_wr_data[gi*LANE_W +: LANE_W];
      end

      always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) r_rd <= '0;
        else if (w_rd_go)      r_rd <= r_mem[w_ridx];
      end

      assign w_byp = r_byp_hit && r_byp_strb[gi];
      assign w_rd_data[gi*LANE_W +: LANE_W] = w_byp ? r_byp_data[gi*LANE_W +: LANE_W] : r_rd;

`ifdef RAM_BANK_PARITY_EN
      logic r_par [DEPTH];
      logic r_rd_par;

      always_ff @(posedge clk) begin
        if (w_wr_strb[gi]) r_par[w_wr_idx] <= lane_parity(w_wr_data[gi*LANE_W +: LANE_W]) ^ w_wr_inj;
      end

      always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) r_rd_par <= 1'b0;
        else if (w_rd_go)      r_rd_par <= r_par[w_ridx];
      end

      // A bypassed lane carries fresh write data, whose parity is consistent by construction.
      assign w_lane_perr[gi] = !w_byp && (lane_parity(r_rd) != r_rd_par);
`else
      assign w_lane_perr[gi] = 1'b0;
`endif
    end
  endgenerate

  logic w_unused;
  assign w_unused = ^{waddr_i, raddr_i, w_wr_inj};

  ram_bank_rdpipe #(
    .DATA_W      (DATA_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_rdpipe (
    .clk    (clk),
    .rst    (rst),
    .i_valid(r_rd_valid),
    .i_data (w_rd_data),
    .i_perr (|w_lane_perr),
    .o_valid(rvalid_o),
    .o_data (rdata_o),
    .o_perr (perr_o)
  );

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: instance a (latency 1, old-data RDW) and instance b
// (latency 2, merged-data RDW) share every input and are checked side by side.
module tb_ram_bank;

`ifdef RAM_BANK_PARITY_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0, pinj = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic        a_ready, a_rvalid, a_perr, b_ready, b_rvalid, b_perr;
  logic [31:0] a_rdata, b_rdata;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ram_bank #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .READ_LATENCY(1), .RDW_NEW(0)) dut_a (
    .clk(clk), .rst(rst), .ready_o(a_ready), .we_i(we), .wstrb_i(wstrb), .waddr_i(waddr),
    .wdata_i(wdata), .re_i(re), .raddr_i(raddr), .rdata_o(a_rdata), .rvalid_o(a_rvalid),
    .perr_o(a_perr), .perr_inject_i(pinj));

  ram_bank #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .READ_LATENCY(2), .RDW_NEW(1)) dut_b (
    .clk(clk), .rst(rst), .ready_o(b_ready), .we_i(we), .wstrb_i(wstrb), .waddr_i(waddr),
    .wdata_i(wdata), .re_i(re), .raddr_i(raddr), .rdata_o(b_rdata), .rvalid_o(b_rvalid),
    .perr_o(b_perr), .perr_inject_i(pinj));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic inj);
    we = 1'b1; waddr = a; wdata = d; wstrb = s; pinj = inj;
    tick();
    we = 1'b0; wstrb = 4'h0; pinj = 1'b0;
  endtask

  task automatic rd_issue(input logic [31:0] a);
    re = 1'b1; raddr = a;
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({a_ready, a_rvalid, a_perr, b_ready, b_rvalid, b_perr} !== 6'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: a r/v/p=%b%b%b b r/v/p=%b%b%b a_rdata=%h b_rdata=%h, want all zero",
               a_ready, a_rvalid, a_perr, b_ready, b_rvalid, b_perr, a_rdata, b_rdata);
    end
    // Writes and reads offered during the clear must be ignored.
    rst = 1'b0; we = 1'b1; waddr = 32'h0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; re = 1'b1; raddr = 32'h0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 15) begin we = 1'b0; wstrb = 4'h0; re = 1'b0; end
      total++;
      if (a_ready !== (k == 15) || b_ready !== (k == 15) || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL clear_ready k=%0d: ready a=%b b=%b rvalid a=%b b=%b, want ready=%b rvalid=0",
                 k, a_ready, b_ready, a_rvalid, b_rvalid, k == 15);
      end
    end
    for (int i = 0; i < 18; i++) begin
      re = (i < 16); raddr = 32'(i * 4);
      tick();
      total++;
      if (a_rvalid !== (i < 16) || b_rvalid !== (i >= 1 && i < 17) || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
        bad++;
        $display("FAIL cleared_read i=%0d: a v=%b d=%h b v=%b d=%h, want a v=%b b v=%b data 0",
                 i, a_rvalid, a_rdata, b_rvalid, b_rdata, i < 16, i >= 1 && i < 17);
      end
    end
    re = 1'b0;
  endtask

  task automatic test_write_strobe;
    wr(32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0);
    wr(32'h40, 32'h0000_00AA, 4'h1, 1'b0);
    wr(32'h40, 32'h5555_5555, 4'h0, 1'b0);
    rd_issue(32'h43);
    total++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEAA || b_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL strobe_lat1: a v=%b d=%h b v=%b, want a v=1 d=deadbeaa b v=0", a_rvalid, a_rdata, b_rvalid);
    end
    tick();
    total++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEAD_BEAA || b_rvalid !== 1'b1 || b_rdata !== 32'hDEAD_BEAA) begin
      bad++;
      $display("FAIL strobe_lat2: a v=%b d=%h b v=%b d=%h, want a v=0 d=deadbeaa b v=1 d=deadbeaa",
               a_rvalid, a_rdata, b_rvalid, b_rdata);
    end
    tick();
    total++;
    if (b_rvalid !== 1'b0 || b_rdata !== 32'hDEAD_BEAA) begin
      bad++;
      $display("FAIL strobe_hold: b v=%b d=%h, want v=0 d=deadbeaa", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_wrap;
    wr(32'h40, 32'h1111_1111, 4'hF, 1'b0);
    rd_issue(32'h00);
    total++;
    if (a_rdata !== 32'h1111_1111) begin
      bad++;
      $display("FAIL wrap_low_a: got %h want 11111111", a_rdata);
    end
    tick();
    total++;
    if (b_rdata !== 32'h1111_1111 || b_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL wrap_low_b: v=%b d=%h want v=1 d=11111111", b_rvalid, b_rdata);
    end
    wr(32'hFFFF_FFFC, 32'hCAFE_F00D, 4'hF, 1'b0);
    rd_issue(32'h3C);
    total++;
    if (a_rdata !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL wrap_high_a: got %h want cafef00d", a_rdata);
    end
    tick();
    total++;
    if (b_rdata !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL wrap_high_b: got %h want cafef00d", b_rdata);
    end
  endtask

  task automatic test_rdw;
    wr(32'h08, 32'hAAAA_AAAA, 4'hF, 1'b0);
    we = 1'b1; waddr = 32'h08; wdata = 32'h1234_5678; wstrb = 4'hC; re = 1'b1; raddr = 32'h0A;
    tick();
    we = 1'b0; wstrb = 4'h0; re = 1'b0;
    total++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hAAAA_AAAA) begin
      bad++;
      $display("FAIL rdw_old: v=%b d=%h want v=1 d=aaaaaaaa", a_rvalid, a_rdata);
    end
    tick();
    total++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h1234_AAAA || b_perr !== 1'b0) begin
      bad++;
      $display("FAIL rdw_new: v=%b d=%h p=%b want v=1 d=1234aaaa p=0", b_rvalid, b_rdata, b_perr);
    end
    // Write to a different word while reading the merged one.
    we = 1'b1; waddr = 32'h0C; wdata = 32'h7777_7777; wstrb = 4'hF; re = 1'b1; raddr = 32'h08;
    tick();
    we = 1'b0; wstrb = 4'h0; re = 1'b0;
    total++;
    if (a_rdata !== 32'h1234_AAAA) begin
      bad++;
      $display("FAIL rdw_other_a: got %h want 1234aaaa", a_rdata);
    end
    tick();
    total++;
    if (b_rdata !== 32'h1234_AAAA) begin
      bad++;
      $display("FAIL rdw_other_b: got %h want 1234aaaa", b_rdata);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) wr(32'(32'h10 + i * 4), 32'h1000_0000 + 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      re = (i < 4); raddr = 32'(32'h10 + i * 4);
      tick();
      total++;
      if (a_rvalid !== (i < 4) || (i < 4 && a_rdata !== 32'h1000_0000 + 32'(i))) begin
        bad++;
        $display("FAIL b2b_a i=%0d: v=%b d=%h want v=%b d=%h", i, a_rvalid, a_rdata, i < 4, 32'h1000_0000 + 32'(i));
      end
      total++;
      if (b_rvalid !== (i >= 1 && i <= 4) || (i >= 1 && i <= 4 && b_rdata !== 32'h1000_0000 + 32'(i - 1))) begin
        bad++;
        $display("FAIL b2b_b i=%0d: v=%b d=%h want v=%b d=%h", i, b_rvalid, b_rdata, i >= 1 && i <= 4,
                 32'h1000_0000 + 32'(i - 1));
      end
    end
    re = 1'b0;
    total++;
    if (a_rdata !== 32'h1000_0003 || b_rdata !== 32'h1000_0003) begin
      bad++;
      $display("FAIL b2b_hold: a=%h b=%h want 10000003", a_rdata, b_rdata);
    end
  endtask

  task automatic test_parity;
    wr(32'h20, 32'h0000_00FF, 4'h1, 1'b1);
    rd_issue(32'h20);
    total++;
    if (a_rvalid !== 1'b1 || a_perr !== PE || a_rdata !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL parity_inj_a: v=%b p=%b d=%h want v=1 p=%b d=000000ff", a_rvalid, a_perr, a_rdata, PE);
    end
    tick();
    total++;
    if (a_perr !== 1'b0 || b_rvalid !== 1'b1 || b_perr !== PE) begin
      bad++;
      $display("FAIL parity_inj_b: a_p=%b b v=%b p=%b want a_p=0 b v=1 p=%b", a_perr, b_rvalid, b_perr, PE);
    end
    tick();
    wr(32'h20, 32'h0000_00FF, 4'h1, 1'b0);
    rd_issue(32'h20);
    total++;
    if (a_rvalid !== 1'b1 || a_perr !== 1'b0) begin
      bad++;
      $display("FAIL parity_clean_a: v=%b p=%b want v=1 p=0", a_rvalid, a_perr);
    end
    tick();
    total++;
    if (b_rvalid !== 1'b1 || b_perr !== 1'b0) begin
      bad++;
      $display("FAIL parity_clean_b: v=%b p=%b want v=1 p=0", b_rvalid, b_perr);
    end
  endtask

  task automatic test_reset_midread;
    rd_issue(32'h40);
    rst = 1'b1;
    tick();
    total++;
    if (b_rvalid !== 1'b0 || a_rvalid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      bad++;
      $display("FAIL midread_flush: b_v=%b a_v=%b ready a=%b b=%b a_d=%h b_d=%h want all zero",
               b_rvalid, a_rvalid, a_ready, b_ready, a_rdata, b_rdata);
    end
    // Interrupt the clear part way, then let it run from index 0 again.
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; re = 1'b1; raddr = 32'h0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 15) re = 1'b0;
      total++;
      if (a_ready !== (k == 15) || b_ready !== (k == 15) || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL reclear_ready k=%0d: ready a=%b b=%b rvalid a=%b b=%b want ready=%b rvalid=0",
                 k, a_ready, b_ready, a_rvalid, b_rvalid, k == 15);
      end
    end
    rd_issue(32'h00);
    rd_issue(32'h3C);
    total++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'h0 || b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reclear_data: a v=%b d=%h b v=%b d=%h want v=1 d=0", a_rvalid, a_rdata, b_rvalid, b_rdata);
    end
    tick();
    total++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reclear_data_b: v=%b d=%h want v=1 d=0", b_rvalid, b_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_strobe();
    test_wrap();
    test_rdw();
    test_back_to_back();
    test_parity();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_bank.md
Name: ram_bank

Overview:
- Parametrised successor to the core's single-port word RAM. Used for instruction/data memory behind the fetch and LSU paths.
- Separate write and read ports; per-byte write strobes; configurable read latency and read-during-write policy.
- On every reset, a clear state machine zeroes the whole array. `ready_o` stays low until the clear completes.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8.
- DEPTH, 4096, number of words; power of two.
- ADDR_W, 32, byte-address width.
- READ_LATENCY, 1, cycles from read request to data; legal values 1 or 2.
- RDW_NEW, 0, read-during-write to same word: 0 returns old data, 1 returns merged new data.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ready_o  out  1  array cleared, ports accepted
- we_i  in  1  write request
- wstrb_i  in  DATA_W/8  byte-lane write enables
- waddr_i  in  ADDR_W  write byte address
- wdata_i  in  DATA_W  write data
- re_i  in  1  read request
- raddr_i  in  ADDR_W  read byte address
- rdata_o  out  DATA_W  read data
- rvalid_o  out  1  rdata_o valid this cycle
- perr_o  out  1  parity error, aligned with rvalid_o
- perr_inject_i  in  1  parity-corruption test hook

Behaviour:
- Reset (rst=1 at a rising edge):
  - state <= CLEAR, clear index <= 0.
  - ready_o=0, rvalid_o=0, rdata_o=0, perr_o=0.
  - Read pipeline flushed.
- FSM states CLEAR and RUN.
  - CLEAR: each cycle writes all-zero data (and matching parity) to the word at the clear index, then increments the index.
  - After the clear of word DEPTH-1, go to RUN.
  - Counting cycles with rst low from 0: cycles 0..DEPTH-1 clear the array; ready_o=1 from cycle DEPTH onward.
- While ready_o=0:
  - we_i and re_i are ignored.
  - No rvalid_o pulse is generated.
- rst asserted mid-clear or mid-read restarts the clear from index 0. Any in-flight read is dropped: no rvalid_o for it.
- Addressing:
  - Word index = addr[log2(DATA_W/8) + log2(DEPTH) - 1 : log2(DATA_W/8)].
  - Byte-offset bits are ignored (misaligned addresses round down).
  - Upper bits are ignored: addresses wrap modulo DEPTH.
- Write (RUN, we_i=1): on the edge, only the bytes with wstrb_i[k]=1 are updated. wstrb_i=0 is a no-op.
- Read (RUN, re_i=1): the address is sampled on the edge.
  - READ_LATENCY=1: rdata_o and rvalid_o are valid in the next cycle.
  - READ_LATENCY=2: one further output register is added.
  - rvalid_o is a one-cycle pulse per request.
  - Back-to-back reads give full throughput.
  - rdata_o holds its last value when rvalid_o=0.
- Simultaneous write and read to the same word:
  - RDW_NEW=0: the read returns the pre-write contents.
  - RDW_NEW=1: strobed bytes come from wdata_i; unstrobed bytes come from the old contents.
  - Different words: fully independent.

Optional Feature:
- Macro: RAM_BANK_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, written alongside the data.
  - On read, parity is recomputed over the read data. perr_o=1 with rvalid_o if any lane mismatches.
  - With the RDW_NEW=1 bypass, parity is computed on the merged data.
  - perr_inject_i=1 during a write stores inverted parity for the strobed lanes.
- Not defined:
  - No parity storage.
  - perr_o is tied to 0.
  - perr_inject_i is ignored.

Decomposition:
- Shared defines header holds:
  - `RST and `WRITE_ENABLE levels.
  - `ZERO_WORD.
  - FSM state encodings RAM_CLEAR and RAM_RUN.
  - The byte-lane width constant.
- One natural sub-module, ram_bank_rdpipe: the READ_LATENCY-deep valid/data/perr register chain with flush on rst.

Test Plan:
1. Reset, DEPTH=16, rst released at cycle 0 -> ready_o=0 through cycle 15 and 1 at cycle 16; reads of all 16 words return 0x00000000.
2. Write 0xDEADBEEF to 0x40 with wstrb=1111, then 0x000000AA with wstrb=0001; read 0x43 (misaligned) -> rdata_o=0xDEADBEAA. rvalid_o pulses 1 cycle later (LAT=1) or 2 cycles later (LAT=2).
3. Wrap test: DEPTH=16, write 0x11111111 to address 0x40 (index 0) -> read of address 0x00 returns 0x11111111.
4. Same-cycle write 0x12345678 (wstrb=1100) and read to a word holding 0xAAAAAAAA -> RDW_NEW=0 returns 0xAAAAAAAA; RDW_NEW=1 returns 0x1234AAAA.
5. Issue a read, assert rst before rvalid_o is due -> no rvalid_o pulse; clear restarts; ready_o low for DEPTH cycles again.
6. With RAM_BANK_PARITY_EN: write 0x000000FF with perr_inject_i=1, wstrb=0001 -> read gives perr_o=1 with rvalid_o; rewrite without injection -> perr_o=0.
